clint: RTL

//  Core-local interruptor: memory-mapped machine software and timer interrupt source.

---
 rtl/clint_pkg.sv | 44 ++++
 rtl/clint_timer.sv | 85 ++++++++
 rtl/clint.sv | 99 +++++++++
 3 files changed

// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets, the decoded
// register select, and bus helper functions.
package clint_pkg;

  localparam logic [15:0] CLINT_MSIP_OFF        = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_LO_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
  localparam logic [15:0] CLINT_MTIME_LO_OFF    = 16'hBFF8;
  localparam logic [15:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;

  typedef enum logic [2:0] {
    RegNone,
    RegMsip,
    RegMtimecmpLo,
    RegMtimecmpHi,
    RegMtimeLo,
    RegMtimeHi
  } clint_reg_e;

  // Decode a word offset (byte offset >> 2) into a register select.
  function automatic clint_reg_e clint_decode(input logic [13:0] word_off);
    clint_reg_e sel;
    sel = RegNone;
    if (word_off == CLINT_MSIP_OFF[15:2])        sel = RegMsip;
    if (word_off == CLINT_MTIMECMP_LO_OFF[15:2]) sel = RegMtimecmpLo;
    if (word_off == CLINT_MTIMECMP_HI_OFF[15:2]) sel = RegMtimecmpHi;
    if (word_off == CLINT_MTIME_LO_OFF[15:2])    sel = RegMtimeLo;
    if (word_off == CLINT_MTIME_HI_OFF[15:2])    sel = RegMtimeHi;
    return sel;
  endfunction

  // Byte-enable merge of new write data over the current register value.
  function automatic logic [31:0] clint_merge(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// Machine timer: 64-bit mtime counter, mtimecmp, and the registered compare that
// drives the timer interrupt. Optional prescaler enabled by CLINT_PRESCALER_EN.
module clint_timer
  import clint_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        mtime_lo_we_i,
  input  logic        mtime_hi_we_i,
  input  logic        mtimecmp_lo_we_i,
  input  logic        mtimecmp_hi_we_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] mtime_o,
  output logic [63:0] mtimecmp_o,
  output logic        timer_irq_o
);

  if (PRESCALE < 1) begin : gen_prescale_chk
    $error("clint_timer: PRESCALE must be at least 1");
  end

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        timer_irq_q;
  logic        mtime_we;
  logic        tick;

  assign mtime_we = mtime_lo_we_i | mtime_hi_we_i;

`ifdef CLINT_PRESCALER_EN
  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

  logic [CntW-1:0] pre_cnt_q, pre_cnt_d;

  // Free-running prescaler; an mtime write restarts the tick period.
  always_comb begin
    tick      = (pre_cnt_q == CntMax);
    pre_cnt_d = pre_cnt_q + 1'b1;
    if (mtime_we || tick) pre_cnt_d = '0;
  end

  // Prescaler state.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) pre_cnt_q <= '0;
    else        pre_cnt_q <= pre_cnt_d;
  end
`else
  assign tick = 1'b1;
`endif

  // A software write to either mtime half overrides that cycle's increment.
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    if (mtime_we) begin
      if (mtime_lo_we_i) mtime_d[31:0]  = wdata_i;
      if (mtime_hi_we_i) mtime_d[63:32] = wdata_i;
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    if (mtimecmp_lo_we_i) mtimecmp_d[31:0]  = wdata_i;
    if (mtimecmp_hi_we_i) mtimecmp_d[63:32] = wdata_i;
  end

  // Timer state and registered compare of the pre-edge values.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      timer_irq_q <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      timer_irq_q <= (mtime_q >= mtimecmp_q);
    end
  end

  assign mtime_o     = mtime_q;
  assign mtimecmp_o  = mtimecmp_q;
  assign timer_irq_o = timer_irq_q;

endmodule

// File: rtl/clint.sv
// Core-local interruptor top: address decode, byte-strobe merge, msip register,
// read mux and single-cycle response pipeline. CLINT_PRESCALER_EN enables the
// mtime prescaler inside clint_timer.
module clint
  import clint_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned AW       = 16,
  parameter int unsigned PRESCALE = 1
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            bus_req,
  input  logic            bus_we,
  input  logic [AW-1:0]   bus_addr,
  input  logic [XLEN-1:0] bus_wdata,
  input  logic [3:0]      bus_wstrb,
  output logic            bus_ready,
  output logic            bus_rvalid,
  output logic [XLEN-1:0] bus_rdata,
  output logic            software_interrupt,
  output logic            timer_interrupt
);

  clint_reg_e      sel;
  logic            wr;
  logic [XLEN-1:0] rd_val;
  logic [31:0]     merged;
  logic [63:0]     mtime;
  logic [63:0]     mtimecmp;
  logic            msip_q, msip_d;
  logic            rvalid_q, rvalid_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            unused_addr;

  // Word aligned access: the low address bits carry no information.
  assign unused_addr = ^bus_addr[1:0];

  assign sel       = clint_decode(bus_addr[15:2]);
  assign wr        = bus_req & bus_we;
  assign bus_ready = 1'b1;

  // Current value of the addressed register; unmapped offsets read as zero.
  always_comb begin
    rd_val = '0;
    unique case (sel)
      RegMsip:       rd_val = {{(XLEN-1){1'b0}}, msip_q};
      RegMtimecmpLo: rd_val = mtimecmp[31:0];
      RegMtimecmpHi: rd_val = mtimecmp[63:32];
      RegMtimeLo:    rd_val = mtime[31:0];
      RegMtimeHi:    rd_val = mtime[63:32];
      default:       rd_val = '0;
    endcase
  end

  assign merged = clint_merge(rd_val, bus_wdata, bus_wstrb);

  clint_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk              (clk),
    .rst_b            (rst_b),
    .mtime_lo_we_i    (wr && (sel == RegMtimeLo)),
    .mtime_hi_we_i    (wr && (sel == RegMtimeHi)),
    .mtimecmp_lo_we_i (wr && (sel == RegMtimecmpLo)),
    .mtimecmp_hi_we_i (wr && (sel == RegMtimecmpHi)),
    .wdata_i          (merged),
    .mtime_o          (mtime),
    .mtimecmp_o       (mtimecmp),
    .timer_irq_o      (timer_interrupt)
  );

  // msip update and response for the accepted request; rdata is zero unless a read.
  always_comb begin
    msip_d   = msip_q;
    rvalid_d = bus_req;
    rdata_d  = '0;
    if (wr && (sel == RegMsip)) msip_d = merged[0];
    if (bus_req && !bus_we)     rdata_d = rd_val;
  end

  // msip and response pipeline registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      msip_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      msip_q   <= msip_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus_rvalid         = rvalid_q;
  assign bus_rdata          = rdata_q;
  assign software_interrupt = msip_q;

endmodule
